// File: rtl/text_console_pkg.sv
// ---------------------------------------------------------------------------
// text_console_pkg
// Shared definitions for the text console writer:
//   - default geometry (COLS x ROWS cells) and RAM widths
//   - control character codes and the blank cell value
//   - FSM state and decoded-operation enums
//   - is_printable() helper
// Optional feature macro used by the writer: TEXT_WRITER_TAB_EN.
// ---------------------------------------------------------------------------
package text_console_pkg;

  localparam int COLS   = 80;
  localparam int ROWS   = 60;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 12;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_TAB   = 8'h09;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  localparam logic [11:0] BLANK_CELL = 12'h020;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_PUT,
    ST_SCROLL,
    ST_BLANK
  } state_t;

  // Operation latched at accept time and carried out in PUT.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_PRINT,
    OP_CR,
    OP_LF,
    OP_BS,
    OP_TAB
  } op_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// ---------------------------------------------------------------------------
// text_console_writer_if
// Byte-stream handshake plus character-RAM port of the text console writer.
//   in_valid/in_ready/in_char/in_attr : byte input (valid/ready)
//   ram_we/ram_waddr/ram_wdata        : RAM write port
//   ram_raddr/ram_rdata               : RAM read port (1-cycle read latency)
// modport master : byte producer and RAM model side
// modport slave  : the writer itself
// ---------------------------------------------------------------------------
interface text_console_writer_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
) ();
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_char;
  logic [3:0]        in_attr;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output in_valid, in_char, in_attr, ram_rdata,
    input  in_ready, ram_we, ram_waddr, ram_wdata, ram_raddr
  );

  modport slave (
    input  in_valid, in_char, in_attr, ram_rdata,
    output in_ready, ram_we, ram_waddr, ram_wdata, ram_raddr
  );
endinterface

// File: rtl/text_cursor.sv
// ---------------------------------------------------------------------------
// text_cursor
// Holds the cursor row/col and the linear cell address row*COLS+col, which is
// maintained incrementally (no multiplier). One strobe per cycle at most.
// Ports:
//   clk, rst                : clock, asynchronous active-high reset
//   inc_i                   : advance one column, wrapping into a line advance
//   dec_i                   : backspace move (col-1, or up to end of prior row)
//   cr_i / lf_i             : carriage return / line feed (LF implies CR)
//   tab_i                   : jump to next multiple of 8, wrapping like inc_i
//   home_i                  : cursor to (0,0)
//   set_last_row_i          : cursor to (ROWS-1, 0)
//   row_o, col_o, addr_o    : cursor position and linear address
//   last_col_o, last_row_o  : cursor on last column / last row
//   origin_o                : cursor at (0,0)
//   tab_wrap_o              : a TAB now would run past the end of the line
// On the last row a line advance keeps the row; the caller scrolls the RAM.
// ---------------------------------------------------------------------------
module text_cursor #(
  parameter int COLS   = text_console_pkg::COLS,
  parameter int ROWS   = text_console_pkg::ROWS,
  parameter int ADDR_W = text_console_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              dec_i,
  input  logic              cr_i,
  input  logic              lf_i,
  input  logic              tab_i,
  input  logic              home_i,
  input  logic              set_last_row_i,
  output logic [5:0]        row_o,
  output logic [6:0]        col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_col_o,
  output logic              last_row_o,
  output logic              origin_o,
  output logic              tab_wrap_o
);
  localparam logic [6:0]        LAST_COL      = 7'(COLS - 1);
  localparam logic [5:0]        LAST_ROW      = 6'(ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);

  logic [5:0]        row_q, row_d;
  logic [6:0]        col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] line_start, next_line;
  logic [7:0]        tab_stop;

  assign last_col_o = (col_q == LAST_COL);
  assign last_row_o = (row_q == LAST_ROW);
  assign origin_o   = (col_q == 7'd0) && (row_q == 6'd0);

  // One bit wider than col so the stop past the last column is representable.
  assign tab_stop   = {1'b0, col_q[6:3], 3'b000} + 8'd8;
  assign tab_wrap_o = (tab_stop >= 8'(COLS));

  // row*COLS obtained by stripping the column off the linear address.
  assign line_start = addr_q - ADDR_W'(col_q);
  assign next_line  = last_row_o ? line_start : line_start + COLS_A;

  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (home_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (set_last_row_i) begin
      row_d  = LAST_ROW;
      col_d  = '0;
      addr_d = LAST_ROW_BASE;
    end else if (cr_i) begin
      col_d  = '0;
      addr_d = line_start;
    end else if (lf_i || (inc_i && last_col_o) || (tab_i && tab_wrap_o)) begin
      col_d  = '0;
      addr_d = next_line;
      if (!last_row_o) row_d = row_q + 6'd1;
    end else if (inc_i) begin
      col_d  = col_q + 7'd1;
      addr_d = addr_q + 1'b1;
    end else if (tab_i) begin
      col_d  = tab_stop[6:0];
      addr_d = addr_q + ADDR_W'(tab_stop[6:0] - col_q);
    end else if (dec_i) begin
      // Stepping back from (r,0) to (r-1,COLS-1) is also just addr-1.
      if (col_q != 7'd0) begin
        col_d  = col_q - 7'd1;
        addr_d = addr_q - 1'b1;
      end else if (row_q != 6'd0) begin
        row_d  = row_q - 6'd1;
        col_d  = LAST_COL;
        addr_d = addr_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign addr_o = addr_q;

endmodule

// File: rtl/text_console_writer.sv
// ---------------------------------------------------------------------------
// text_console_writer
// Writer side of the COLS x ROWS text-mode character RAM. Accepts ASCII bytes
// over valid/ready, keeps a cursor, writes {attr, ascii} cells, handles
// CR/LF/BS/FF, auto-wraps, scrolls one line at the bottom and clears the RAM
// after reset.
// Ports:
//   clk     : clock (RAM write/read port domain)
//   rst     : asynchronous active-high reset
//   bus     : text_console_writer_if.slave (byte handshake + RAM port)
//   cur_row : cursor row, cur_col : cursor column
//   busy    : high whenever the FSM is not IDLE
// Optional: define TEXT_WRITER_TAB_EN to make 0x09 advance to the next
// multiple-of-8 column; otherwise 0x09 is ignored.
// ---------------------------------------------------------------------------
module text_console_writer #(
  parameter int COLS   = text_console_pkg::COLS,
  parameter int ROWS   = text_console_pkg::ROWS,
  parameter int ADDR_W = text_console_pkg::ADDR_W,
  parameter int DATA_W = text_console_pkg::DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  text_console_writer_if.slave bus,
  output logic [5:0]           cur_row,
  output logic [6:0]           cur_col,
  output logic                 busy
);
  import text_console_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
  localparam logic [DATA_W-1:0] BLANK_D       = DATA_W'(BLANK_CELL);

  state_t            state_q;
  op_t               op_q, in_op;
  logic              ram_we_q, reading_q, busy_q;
  logic [ADDR_W-1:0] waddr_q, raddr_q, cur_addr;
  logic [DATA_W-1:0] wdata_q;

  logic at_last_col, at_last_row, at_origin, tab_wraps, scroll_needed;
  logic cur_inc, cur_dec, cur_cr, cur_lf, cur_tab, cur_home, cur_last;

  text_cursor #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) u_cursor (
    .clk            (clk),
    .rst            (rst),
    .inc_i          (cur_inc),
    .dec_i          (cur_dec),
    .cr_i           (cur_cr),
    .lf_i           (cur_lf),
    .tab_i          (cur_tab),
    .home_i         (cur_home),
    .set_last_row_i (cur_last),
    .row_o          (cur_row),
    .col_o          (cur_col),
    .addr_o         (cur_addr),
    .last_col_o     (at_last_col),
    .last_row_o     (at_last_row),
    .origin_o       (at_origin),
    .tab_wrap_o     (tab_wraps)
  );

  // Classify the offered byte. BS at (0,0) moves nothing, so it writes nothing.
  always_comb begin
    in_op = OP_NONE;
    if (is_printable(bus.in_char)) begin
      in_op = OP_PRINT;
    end else begin
      case (bus.in_char)
        CH_CR:   in_op = OP_CR;
        CH_LF:   in_op = OP_LF;
        CH_BS:   in_op = at_origin ? OP_NONE : OP_BS;
`ifdef TEXT_WRITER_TAB_EN
        CH_TAB:  in_op = OP_TAB;
`endif
        default: in_op = OP_NONE;
      endcase
    end
  end

  // Cursor moves happen on the edge that leaves PUT; clear/blank end fix it up.
  assign cur_inc  = (state_q == ST_PUT) && (op_q == OP_PRINT);
  assign cur_dec  = (state_q == ST_PUT) && (op_q == OP_BS);
  assign cur_cr   = (state_q == ST_PUT) && (op_q == OP_CR);
  assign cur_lf   = (state_q == ST_PUT) && (op_q == OP_LF);
  assign cur_tab  = (state_q == ST_PUT) && (op_q == OP_TAB);
  assign cur_home = (state_q == ST_CLEAR) && ram_we_q && (waddr_q == LAST_ADDR);
  assign cur_last = (state_q == ST_BLANK) && (waddr_q == LAST_ADDR);

  assign scroll_needed = at_last_row &&
                         (((op_q == OP_PRINT) && at_last_col) ||
                          (op_q == OP_LF) ||
                          ((op_q == OP_TAB) && tab_wraps));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      op_q      <= OP_NONE;
      ram_we_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      reading_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          busy_q  <= 1'b1;
          wdata_q <= BLANK_D;
          if (!ram_we_q) begin
            // First cycle after reset: no write yet, start at cell 0.
            ram_we_q <= 1'b1;
            waddr_q  <= '0;
          end else if (waddr_q == LAST_ADDR) begin
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            waddr_q <= waddr_q + 1'b1;
          end
        end

        ST_IDLE: begin
          if (bus.in_valid) begin
            busy_q <= 1'b1;
            if (bus.in_char == CH_FF) begin
              // Start writing cell 0 straight away so the clear is exactly
              // one write per cycle with no idle lead-in.
              state_q  <= ST_CLEAR;
              ram_we_q <= 1'b1;
              waddr_q  <= '0;
              wdata_q  <= BLANK_D;
            end else begin
              state_q  <= ST_PUT;
              op_q     <= in_op;
              ram_we_q <= (in_op == OP_PRINT) || (in_op == OP_BS);
              if (in_op == OP_BS) begin
                // Backspace blanks the cell it moves to, which is always addr-1.
                waddr_q <= cur_addr - 1'b1;
                wdata_q <= DATA_W'({bus.in_attr, CH_SPACE});
              end else begin
                waddr_q <= cur_addr;
                wdata_q <= DATA_W'({bus.in_attr, bus.in_char});
              end
            end
          end
        end

        ST_PUT: begin
          ram_we_q <= 1'b0;
          if (scroll_needed) begin
            state_q   <= ST_SCROLL;
            raddr_q   <= COLS_A;
            reading_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_SCROLL: begin
          // Read k this cycle, write k-COLS next cycle with the returned data.
          if (reading_q) begin
            ram_we_q <= 1'b1;
            waddr_q  <= raddr_q - COLS_A;
            if (raddr_q == LAST_ADDR) begin
              reading_q <= 1'b0;
              raddr_q   <= '0;
            end else begin
              raddr_q <= raddr_q + 1'b1;
            end
          end else begin
            // Drain cycle just wrote the final copy; blank the last row next.
            state_q  <= ST_BLANK;
            ram_we_q <= 1'b1;
            waddr_q  <= LAST_ROW_BASE;
            wdata_q  <= BLANK_D;
          end
        end

        ST_BLANK: begin
          if (waddr_q == LAST_ADDR) begin
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end else begin
            waddr_q <= waddr_q + 1'b1;
          end
        end

        default: begin
          state_q  <= ST_CLEAR;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_waddr = waddr_q;
  assign bus.ram_raddr = raddr_q;
  // Scroll copies forward the RAM read data in the cycle it arrives.
  assign bus.ram_wdata = (state_q == ST_SCROLL) ? bus.ram_rdata : wdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
// ---------------------------------------------------------------------------
// tb_text_console_writer
// Drives bytes into text_console_writer, models the screen as a flat array of
// cells and queues every RAM write the screen rules imply; a monitor pops the
// queue on each DUT write. Also models the character RAM (1-cycle read).
// Honours TEXT_WRITER_TAB_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_text_console_writer;
  import text_console_pkg::*;

  localparam int NC    = 80;
  localparam int NR    = 60;
  localparam int CELLS = NC * NR;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] cur_row;
  logic [6:0] cur_col;
  logic       busy;

  text_console_writer_if #(.ADDR_W(13), .DATA_W(12)) bus ();

  text_console_writer #(.COLS(NC), .ROWS(NR), .ADDR_W(13), .DATA_W(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int tx_num = 0;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  mon_e;
  int   scr[CELLS];
  int   m_row, m_col;
  logic [11:0] mem[CELLS];

  // Character RAM: write port plus registered read.
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor: every DUT write must match the next expected write.
  always @(negedge clk) begin
    if (!rst && bus.ram_we) begin
      check("no_write_in_idle", bus.in_ready, 1'b0);
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected no write",
                 bus.ram_waddr, bus.ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", bus.ram_waddr, mon_e.addr);
        check("write_data", bus.ram_wdata, mon_e.data);
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_w(input int a, input int d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
    scr[a] = d;
  endtask

  task automatic model_clear();
    for (int a = 0; a < CELLS; a++) push_w(a, 'h020);
    m_row = 0;
    m_col = 0;
  endtask

  // Returns extra cycles spent scrolling (0 when no scroll).
  task automatic model_newline(output int extra);
    extra = 0;
    if (m_row < NR - 1) begin
      m_row++;
    end else begin
      for (int k = NC; k < CELLS; k++) push_w(k - NC, scr[k]);
      for (int c = 0; c < NC; c++) push_w(CELLS - NC + c, 'h020);
      extra = (NR - 1) * NC + 1 + NC;
    end
  endtask

  // lat = clock edges after the accepting edge until in_ready is high again.
  task automatic model_byte(input int ch, input int attr, output int lat);
    int extra;
    lat = 1;
    if (ch >= 'h20 && ch <= 'h7E) begin
      push_w(m_row * NC + m_col, attr * 256 + ch);
      m_col++;
      if (m_col == NC) begin
        m_col = 0;
        model_newline(extra);
        lat += extra;
      end
    end else if (ch == 'h0D) begin
      m_col = 0;
    end else if (ch == 'h0A) begin
      m_col = 0;
      model_newline(extra);
      lat += extra;
    end else if (ch == 'h08) begin
      if (m_col > 0) begin
        m_col--;
        push_w(m_row * NC + m_col, attr * 256 + 'h20);
      end else if (m_row > 0) begin
        m_row--;
        m_col = NC - 1;
        push_w(m_row * NC + m_col, attr * 256 + 'h20);
      end
    end else if (ch == 'h0C) begin
      model_clear();
      lat = CELLS;
    end
`ifdef TEXT_WRITER_TAB_EN
    else if (ch == 'h09) begin
      m_col = (m_col / 8 + 1) * 8;
      if (m_col >= NC) begin
        m_col = 0;
        model_newline(extra);
        lat += extra;
      end
    end
`endif
  endtask

  // ---------------- stimulus ----------------
  task automatic send(input int ch, input int attr);
    int lat;
    int n;
    @(negedge clk);
    check("ready_before_send", bus.in_ready, 1'b1);
    model_byte(ch, attr, lat);
    bus.in_valid = 1'b1;
    bus.in_char  = ch[7:0];
    bus.in_attr  = attr[3:0];
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 12000) begin
      @(posedge clk);
      #1;
      n++;
    end
    tx_num++;
    $display("tx %0d: char=0x%02h attr=0x%0h -> row=%0d col=%0d cycles=%0d",
             tx_num, ch[7:0], attr[3:0], cur_row, cur_col, n + 1);
    check("turnaround", n, lat);
    check("cur_row", cur_row, m_row);
    check("cur_col", cur_col, m_col);
    check("pending_writes", exp_q.size(), 0);
    check("raddr_idle", bus.ram_raddr, 0);
  endtask

  task automatic release_reset();
    int n;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) begin
        check("clear_busy", busy, 1'b1);
        check("clear_we", bus.ram_we, 1'b1);
      end
    end while (!bus.in_ready && n < 10000);
    tx_num++;
    $display("tx %0d: reset release -> clear done after %0d cycles", tx_num, n);
    check("clear_cycles", n, CELLS + 1);
    check("clear_row", cur_row, 0);
    check("clear_col", cur_col, 0);
    check("clear_pending", exp_q.size(), 0);
  endtask

  function automatic int rand_print();
    return int'($urandom_range(32, 126));
  endfunction

  task automatic send_random();
    int r;
    int ch;
    r = int'($urandom_range(0, 31));
    if (r < 20)      ch = rand_print();
    else if (r < 22) ch = 'h0A;
    else if (r == 22) ch = 'h0D;
    else if (r < 25) ch = 'h08;
    else if (r < 27) ch = 'h09;
    else if (r < 29) begin
      ch = int'($urandom_range(0, 31));
      if (ch == 'h0C) ch = 'h00;
    end else ch = int'($urandom_range(127, 255));
    send(ch, int'($urandom_range(0, 15)));
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    bus.in_attr  = 4'h0;
    m_row = 0;
    m_col = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", bus.ram_we, 1'b0);
    check("rst_ready", bus.in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_row", cur_row, 0);
    check("rst_col", cur_col, 0);
    check("rst_raddr", bus.ram_raddr, 0);
    check("rst_waddr", bus.ram_waddr, 0);
    release_reset();

    // 'A' with attr 3 at origin.
    send('h41, 3);

    // Wrap at end of row 5, then backspace over the wrap.
    send('h0C, 0);
    repeat (5) send('h0A, 0);
    repeat (79) send(rand_print(), int'($urandom_range(0, 15)));
    send('h5A, 7);
    send('h08, 2);

    // TAB from column 3, then from column 77.
    send('h0C, 0);
    repeat (3) send(rand_print(), 1);
    send('h09, 1);
    send('h0D, 0);
    repeat (77) send(rand_print(), 4);
    send('h09, 1);

    // Line feed on the last row forces a scroll.
    while (m_row < NR - 1) send('h0A, 0);
    repeat (10) send(rand_print(), int'($urandom_range(0, 15)));
    send('h0A, 0);

    // Random mix from a clean screen.
    send('h0C, 0);
    for (int i = 0; i < 200; i++) send_random();

    // Reset asserted in the middle of a scroll.
    while (m_row < NR - 1) send('h0A, 0);
    @(negedge clk);
    model_byte('h0A, 0, lat);
    bus.in_valid = 1'b1;
    bus.in_char  = 8'h0A;
    bus.in_attr  = 4'h0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_we", bus.ram_we, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_ready", bus.in_ready, 1'b0);
    check("abort_raddr", bus.ram_raddr, 0);
    check("abort_wdata", bus.ram_wdata, 0);
    check("abort_row", cur_row, 0);
    check("abort_col", cur_col, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    release_reset();

    // Random traffic near the bottom so wraps and LFs scroll.
    repeat (57) send('h0A, 0);
    for (int i = 0; i < 40; i++) send_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5000000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Writer side of the 80x60 text-mode character buffer that the VGA text controller scans out.
- Accepts a stream of ASCII bytes over a valid/ready handshake and maintains a cursor.
- Writes character cells into the dual-port character RAM, with cell address = row*COLS + col and cell data = {attr[3:0], ascii[7:0]}.
- Handles CR, LF, BS and FF, auto-wraps at end of line, scrolls the screen up one line when the cursor passes the last row, and clears the RAM after reset.

Parameters:
- COLS, 80, characters per line.
- ROWS, 60, lines per screen.
- ADDR_W, 13, character RAM address width; COLS*ROWS must be <= 2**ADDR_W.
- DATA_W, 12, cell width: {attr[3:0], ascii[7:0]}.

Ports:
- clk  in  1  system clock (same domain as the RAM write/read port).
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  byte offered.
- in_ready  out  1  block can accept a byte this cycle.
- in_char  in  8  ASCII byte.
- in_attr  in  4  attribute nibble; latched together with in_char.
- ram_we  out  1  RAM write strobe.
- ram_waddr  out  ADDR_W  RAM write address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_raddr  out  ADDR_W  RAM read address; used for scrolling only.
- ram_rdata  in  DATA_W  RAM read data; valid exactly 1 cycle after ram_raddr.
- cur_row  out  6  cursor row, 0..ROWS-1.
- cur_col  out  7  cursor column, 0..COLS-1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (asynchronous):
  - All outputs are 0.
  - Cursor is (0,0) and the linear cursor address cur_addr is 0.
  - The FSM enters CLEAR.
  - Reset asserted mid-operation aborts the operation immediately; after release the block restarts CLEAR.
- No multiplier: cur_addr is updated incrementally (+1, -1, +COLS, -COLS, or set to row*COLS via a col subtraction).
- FSM states: CLEAR, IDLE, PUT, SCROLL, BLANK.
- Handshake:
  - in_ready = (state == IDLE).
  - A byte transfers when in_valid && in_ready; in_char and in_attr are latched on that edge.
  - in_ready is low for at least 1 cycle after every accept, so back-to-back bytes take at least 2 cycles each.
- CLEAR:
  - Writes {4'h0, 8'h20} to addresses 0..COLS*ROWS-1, one per cycle (4800 cycles at default parameters).
  - Sets the cursor to (0,0), then goes to IDLE.
- Printable byte (0x20..0x7E):
  - In PUT, the cycle after accept, assert ram_we with ram_waddr = cur_addr and ram_wdata = {attr, char}.
  - Then advance: col+1. If col was COLS-1, set col=0 and do a line advance.
  - Without a scroll, return to IDLE (2-cycle turnaround).
- Line advance: if row < ROWS-1, row+1 and cur_addr moves accordingly. If row == ROWS-1, go to SCROLL; the row stays ROWS-1.
- 0x0D CR: col=0, no write.
- 0x0A LF: col=0 plus a line advance (LF implies CR).
- 0x08 BS:
  - If col>0: col-1.
  - Else if row>0: go to (row-1, COLS-1).
  - Else (0,0): no move.
  - When the cursor moves, write space with the latched attr at the new position via PUT, without advancing afterwards.
- 0x0C FF: enter CLEAR, then home the cursor.
- All other bytes (0x00..0x1F not listed, 0x7F..0xFF): accepted and ignored; return to IDLE next cycle.
- SCROLL (pipelined copy):
  - Read address k runs COLS..COLS*ROWS-1, one per cycle.
  - One cycle later, write ram_rdata to address k-COLS.
  - Lasts (ROWS-1)*COLS+1 cycles, including the drain cycle.
- BLANK: writes {4'h0, 8'h20} to the last row (COLS cycles), then IDLE with the cursor at (ROWS-1, 0).
- A write is never issued to an address >= COLS*ROWS.
- ram_raddr is 0 outside SCROLL.
- ram_we is never asserted in IDLE.

Optional Feature:
- Macro: TEXT_WRITER_TAB_EN.
- Defined: 0x09 TAB advances col to the next multiple of 8 with no writes. If that would reach COLS or beyond, it wraps with a line advance (and scroll if needed).
- Undefined: 0x09 is ignored like other control codes.

Decomposition:
- Shared package text_console_pkg holds:
  - COLS, ROWS, ADDR_W, DATA_W defaults.
  - Character constants CH_BS, CH_TAB, CH_LF, CH_FF, CH_CR, CH_SPACE.
  - Blank-cell constant BLANK_CELL = 12'h020.
  - FSM state enum.
- One natural sub-module: text_cursor, which holds row, col and cur_addr and takes inc, dec, cr, lf, home and set_last_row strobes, with wrap flags as outputs. The RAM sequencing stays in the top module.

Test Plan:
- Reset release -> busy high and ram_we high for exactly 4800 consecutive cycles, addresses 0..4799, data 0x020; then in_ready=1 and cursor (0,0).
- Send 'A' (0x41) with attr 0x3 -> one write: addr 0, data 0x341. Cursor becomes (0,1); in_ready returns 2 cycles after accept.
- Cursor at (5,79), send 'Z' -> write at addr 479; cursor becomes (6,0). Then BS -> space written at addr 479 (5*80+79), cursor (5,79).
- Cursor at (59,10), send LF -> SCROLL:
  - cell 80 copied to 0 and cell 4799 copied to 4719.
  - Addresses 4720..4799 are then blanked.
  - Cursor ends at (59,0); the cycle count is 4721+80.
- Send FF mid-screen -> full 4800-cycle clear and cursor (0,0). Assert rst during SCROLL -> outputs go to 0 immediately and CLEAR restarts after release.
- With TEXT_WRITER_TAB_EN, cursor (0,3), send TAB -> cursor (0,8) with no write. At (0,77), TAB -> cursor (1,0). Without the macro, cursor is unchanged.
